refill_arbiter: RTL

- Shares the single external read-burst port between the I-cache and D-cache refill engines.
- Sequences each refill as an address phase followed by a data phase.
- Routes the returned beats to the owning cache.
- Discards an in-flight I-cache refill when the front end is flushed.
- Sits between the caches and the bus interface. The caches hold their stall requests to the pipeline controller until their refill's last beat arrives.

---
 rtl/refill_arbiter_pkg.sv | 19 +
 rtl/refill_beat_checker.sv | 53 +++++
 rtl/refill_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/refill_arbiter_pkg.sv
// rtl/refill_arbiter_pkg.sv - shared encodings and default widths for the refill arbiter
package refill_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_LEN_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_e;

endpackage

// File: rtl/refill_beat_checker.sv
// rtl/refill_beat_checker.sv - holds the granted burst length and beat count, flags length mismatches
module refill_beat_checker #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN_W-1:0] len_in,
   input  logic             start,
   input  logic             beat,
   input  logic             last,
   output logic [LEN_W-1:0] len,
   output logic             proto_err
);

   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   always_comb begin
      len_d = len_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (load) begin
         len_d = len_in;
      end
      if (start) begin
         cnt_d = '0;
      end else if (beat) begin
         cnt_d = cnt_q + 1'b1;
         // early last or missing last both mean the bus disagrees with the granted length
         if ((last && (cnt_q != len_q)) || (!last && (cnt_q == len_q))) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         len_q <= len_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign len       = len_q;
   assign proto_err = err_q;

endmodule

// File: rtl/refill_arbiter.sv
// rtl/refill_arbiter.sv - shares one read-burst port between I-cache and D-cache refills
// Optional REFILL_RR_EN selects round-robin arbitration instead of fixed D-cache priority.
module refill_arbiter
   import refill_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic [LEN_W-1:0]  ic_len,
   output logic              ic_gnt,
   output logic              ic_rvalid,
   output logic              ic_rlast,
   input  logic              dc_req,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LEN_W-1:0]  dc_len,
   output logic              dc_gnt,
   output logic              dc_rvalid,
   output logic              dc_rlast,
   output logic [DATA_W-1:0] rdata,
   input  logic              ic_flush,
   output logic              ar_valid,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [LEN_W-1:0]  ar_len,
   input  logic              ar_ready,
   input  logic              r_valid,
   input  logic [DATA_W-1:0] r_data,
   input  logic              r_last,
   output logic              r_ready,
   output logic              busy,
   output logic              proto_err
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              gnt_q, gnt_d;
   logic              drop_q, drop_d;
   logic              grant, pick_dc, beat, ar_fire;
   logic [LEN_W-1:0]  len_in;

`ifdef REFILL_RR_EN
   owner_e last_owner_q, last_owner_d;

   // on a tie the cache that was not granted last wins
   assign pick_dc = dc_req && (!ic_req || (last_owner_q == OWN_IC));

   always_comb begin
      last_owner_d = last_owner_q;
      if (grant) begin
         last_owner_d = pick_dc ? OWN_DC : OWN_IC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner_q <= OWN_IC;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`else
   assign pick_dc = dc_req;
`endif

   assign grant   = (state_q == ST_IDLE) && (dc_req || ic_req);
   assign ar_fire = (state_q == ST_ADDR) && ar_ready;
   assign beat    = (state_q == ST_DATA) && r_valid;
   assign len_in  = pick_dc ? dc_len : ic_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (dc_req || ic_req)  state_d = ST_ADDR;
         ST_ADDR: if (ar_ready)          state_d = ST_DATA;
         ST_DATA: if (r_valid && r_last) state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      owner_d = owner_q;
      addr_d  = addr_q;
      gnt_d   = grant;
      drop_d  = drop_q;
      if (grant) begin
         owner_d = pick_dc ? OWN_DC : OWN_IC;
         addr_d  = pick_dc ? dc_addr : ic_addr;
      end
      if ((state_q != ST_IDLE) && (owner_q == OWN_IC) && ic_flush) begin
         drop_d = 1'b1;
      end
      if (beat && r_last) begin
         drop_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_DC;
         addr_q  <= '0;
         gnt_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         addr_q  <= addr_d;
         gnt_q   <= gnt_d;
         drop_q  <= drop_d;
      end
   end

   refill_beat_checker #(.LEN_W(LEN_W)) u_checker (
      .clk       (clk),
      .rst       (rst),
      .load      (grant),
      .len_in    (len_in),
      .start     (ar_fire),
      .beat      (beat),
      .last      (r_last),
      .len       (ar_len),
      .proto_err (proto_err)
   );

   // a flush in the same cycle as a beat must already hide that beat
   always_comb begin
      ar_valid  = (state_q == ST_ADDR);
      ar_addr   = addr_q;
      r_ready   = (state_q == ST_DATA);
      busy      = (state_q != ST_IDLE);
      ic_gnt    = gnt_q && (owner_q == OWN_IC);
      dc_gnt    = gnt_q && (owner_q == OWN_DC);
      ic_rvalid = beat && (owner_q == OWN_IC) && !drop_q && !ic_flush;
      dc_rvalid = beat && (owner_q == OWN_DC);
      ic_rlast  = ic_rvalid && r_last;
      dc_rlast  = dc_rvalid && r_last;
      rdata     = beat ? r_data : '0;
   end

endmodule
